fifo_wptr_full: RTL and testbench
=================================

# fifo_wptr_full

Write-side control stage of the dual-clock FIFO, running entirely in the write clock domain. It sits directly upstream of the FIFO storage array. It drives the array's write enable and write address, and it produces the Gray-coded write pointer that goes to the read domain. It synchronises the read domain's Gray pointer into `wclk` and derives full, almost-full, fill level and overflow status from it.

## Interface
Parameters:
- `ADDRSIZE`, 4: storage address bits; DEPTH = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
- `AFULL_MARGIN`, 2: `walmost_full` asserts when fill ≥ DEPTH − AFULL_MARGIN; legal range 1..DEPTH−1.

Ports:
- `wclk` in 1: write clock; all state on rising edge.
- `wrst_n` in 1: reset, asynchronous and active-low; release is synchronous to `wclk` externally.
- `winc` in 1: write request for the current cycle.
- `wrptr_gray` in ADDRSIZE+1: Gray read pointer from the read domain, asynchronous to `wclk`.
- `wovf_clr` in 1: clears sticky overflow.
- `wclken` out 1: storage write enable = `winc && !wfull`, combinational.
- `waddr` out ADDRSIZE: storage write address = low ADDRSIZE bits of the binary write pointer.
- `wptr` out ADDRSIZE+1: registered Gray write pointer, sent to the read domain.
- `wfull` out 1: registered full flag.
- `walmost_full` out 1: registered almost-full flag.
- `wcount` out ADDRSIZE+1: registered fill level, 0..DEPTH.
- `wovf` out 1: sticky overflow flag.
- `wovf_cnt` out 16: overflow event count (see Configuration).

## Operation
- Synchroniser: two-flop chain `wq1_rptr` → `wq2_rptr` on `wrptr_gray`. No logic sits between the two flops. `wq2_rptr` is the only read-pointer value used.
- Binary pointer `wbin` (ADDRSIZE+1 bits) holds the write position.
  - `wbin_next = wbin + (winc && !wfull)`, modulo 2^(ADDRSIZE+1).
  - `wgray_next = wbin_next ^ (wbin_next >> 1)`.
  - Each edge, `wbin` takes `wbin_next` and `wptr` takes `wgray_next`.
- Full: `wfull` takes `(wgray_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]})`.
- Fill level: `wcount` takes `wbin_next − gray2bin(wq2_rptr)`, modulo 2^(ADDRSIZE+1), computed at ADDRSIZE+1 bits.
- Almost full: `walmost_full` takes `(wbin_next − gray2bin(wq2_rptr)) ≥ DEPTH − AFULL_MARGIN`.
- Flags are pessimistic.
  - Full and count may lag reads by the synchroniser latency.
  - Full never lags writes.
- Overflow event: a cycle with `winc && wfull`.
  - The write is dropped, `wclken` is 0 and `wbin` holds.
  - `wovf` sets on the next edge.
  - `wovf_clr` clears `wovf`; if an event occurs in the same cycle, set wins.
- Simultaneous write and read-pointer update: both are applied in the same computation; there is no priority issue.

## Timing
- Reset (async assert): `wbin`, `wptr`, `waddr`, `wq1_rptr`, `wq2_rptr` = 0; `wfull` = 0, `walmost_full` = 0, `wcount` = 0, `wovf` = 0, `wovf_cnt` = 0.
  - `wclken` follows `winc` after reset, since `wfull` = 0.
  - Reset mid-operation discards all state; the read side must be reset together with the write side.
- Write accepted in cycle N (`wclken` = 1 at edge N):
  - `waddr`, `wptr` and `wcount` advance at edge N.
  - `wfull` and `walmost_full` reflect that write at edge N, with no extra cycle.
  - A write in cycle N+1 is already blocked if the write at N filled the FIFO.
- Read pointer change on `wrptr_gray` before edge E:
  - Captured at edge E into `wq1_rptr`, and at E+1 into `wq2_rptr`.
  - `wfull`, `walmost_full` and `wcount` reflect it at edge E+2, i.e. 3 edges.
- Wrap-around: `waddr` wraps DEPTH−1 → 0. `wptr` changes exactly one bit per accepted write, including the wrap at 2^(ADDRSIZE+1)−1 → 0.

## Configuration
- `FIFO_WPTR_FULL_OVF_CNT_EN` defined:
  - `wovf_cnt` is a 16-bit counter that increments on every overflow event and saturates at 0xFFFF.
  - `wovf_clr` zeroes it; if an event occurs in the same cycle, the counter is set to 1.
- Not defined: `wovf_cnt` is tied to 0, no counter flops exist, and the `wovf` flag behaves identically.

## Test plan
- Reset mid-stream after 5 writes: all outputs listed under Timing are 0 immediately, asynchronously. After release, the first write uses `waddr` 0.
- ADDRSIZE=4, AFULL_MARGIN=2, `wrptr_gray`=0, 16 consecutive writes:
  - `walmost_full` = 1 at the edge of the 14th write.
  - `wfull` = 1 and `wcount` = 16 at the edge of the 16th write.
  - `wptr` = 5'b11000.
- Full FIFO with `winc` held 3 cycles: `wclken` = 0, `waddr` stays 0, and `wovf` = 1. With the macro, `wovf_cnt` = 3; without it, `wovf_cnt` = 0.
- Full FIFO, then `wrptr_gray` changes to 5'b00001: `wfull` = 0 and `wcount` = 15 exactly 3 edges later, and the next write is accepted at `waddr` 0.
- 40 writes with `wrptr_gray` following `wptr` 4 cycles behind:
  - `wfull` stays 0.
  - `waddr` wraps 15→0 twice.
  - Every `wptr` step has Hamming distance 1, including the 31→0 wrap.
- `wovf_clr` asserted in the same cycle as a new overflow event: `wovf` stays 1. With the macro, `wovf_cnt` becomes 1.

Source files
------------

// File: rtl/fifo_wptr_full.sv
//==============================================================================
// Module   : fifo_wptr_full
// Brief    : Write-side pointer, full/almost-full, fill level and overflow
//            logic of a dual-clock FIFO; all state in the wclk domain.
//            Define FIFO_WPTR_FULL_OVF_CNT_EN to add a saturating 16-bit
//            overflow event counter on wovf_cnt (otherwise tied to zero).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fifo_wptr_full #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wrptr_gray,
    input  logic                wovf_clr,
    output logic                wclken,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wcount,
    output logic                wovf,
    output logic [15:0]         wovf_cnt
);

    localparam int              c_DEPTH       = 2 ** ADDRSIZE;
    localparam logic [ADDRSIZE:0] c_AFULL_LEVEL = (ADDRSIZE + 1)'(c_DEPTH - AFULL_MARGIN);

    logic [ADDRSIZE:0] r_wq1_rptr;
    logic [ADDRSIZE:0] r_wq2_rptr;
    logic [ADDRSIZE:0] r_wbin;
    logic [ADDRSIZE:0] r_wptr;
    logic              r_wfull;
    logic              r_walmost_full;
    logic [ADDRSIZE:0] r_wcount;
    logic              r_wovf;

    logic [ADDRSIZE:0] w_wbin_next;
    logic [ADDRSIZE:0] w_wgray_next;
    logic [ADDRSIZE:0] w_rbin;
    logic [ADDRSIZE:0] w_fill;
    logic              w_ovf_event;

    // Plain two-flop synchroniser; nothing may sit between the stages.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wq1_rptr <= '0;
            r_wq2_rptr <= '0;
        end else begin
            r_wq1_rptr <= wrptr_gray;
            r_wq2_rptr <= r_wq1_rptr;
        end
    end

    always_comb begin
        w_rbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            w_rbin[i] = ^(r_wq2_rptr >> i);
        end
    end

    assign wclken       = winc && !r_wfull;
    assign w_ovf_event  = winc && r_wfull;
    assign w_wbin_next  = r_wbin + {{ADDRSIZE{1'b0}}, wclken};
    assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
    assign w_fill       = w_wbin_next - w_rbin;

    // Flags use the post-write pointer so a filling write blocks the next cycle.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wcount       <= '0;
        end else begin
            r_wbin         <= w_wbin_next;
            r_wptr         <= w_wgray_next;
            r_wfull        <= (w_wgray_next == {~r_wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                                 r_wq2_rptr[ADDRSIZE-2:0]});
            r_walmost_full <= (w_fill >= c_AFULL_LEVEL);
            r_wcount       <= w_fill;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wovf <= 1'b0;
        end else if (w_ovf_event) begin
            r_wovf <= 1'b1;
        end else if (wovf_clr) begin
            r_wovf <= 1'b0;
        end
    end

`ifdef FIFO_WPTR_FULL_OVF_CNT_EN
    logic [15:0] r_wovf_cnt;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wovf_cnt <= '0;
        end else if (w_ovf_event) begin
            if (wovf_clr) begin
                r_wovf_cnt <= 16'd1;
            end else if (r_wovf_cnt != 16'hFFFF) begin
                r_wovf_cnt <= r_wovf_cnt + 16'd1;
            end
        end else if (wovf_clr) begin
            r_wovf_cnt <= '0;
        end
    end

    assign wovf_cnt = r_wovf_cnt;
`else
    assign wovf_cnt = '0;
`endif

    assign waddr        = r_wbin[ADDRSIZE-1:0];
    assign wptr         = r_wptr;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wcount       = r_wcount;
    assign wovf         = r_wovf;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wptr_full.sv
//==============================================================================
// Module   : tb_fifo_wptr_full
// Brief    : Self-checking bench for fifo_wptr_full against a position-based
//            behavioural model of the write side.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fifo_wptr_full;

    localparam int c_AS    = 4;
    localparam int c_DEPTH = 16;
    localparam int c_MOD   = 32;
    localparam int c_MARG  = 2;

    logic        wclk = 1'b0;
    logic        wrst_n = 1'b0;
    logic        winc = 1'b0;
    logic [4:0]  wrptr_gray = '0;
    logic        wovf_clr = 1'b0;
    logic        wclken;
    logic [3:0]  waddr;
    logic [4:0]  wptr;
    logic        wfull;
    logic        walmost_full;
    logic [4:0]  wcount;
    logic        wovf;
    logic [15:0] wovf_cnt;

    int errors = 0;
    int checks = 0;

    // Model: write position and synchronised read position as plain integers.
    int m_wpos, m_rq1, m_rq2, m_count, m_cnt;
    bit m_full, m_afull, m_ovf;

    fifo_wptr_full #(.ADDRSIZE(c_AS), .AFULL_MARGIN(c_MARG)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wrptr_gray   (wrptr_gray),
        .wovf_clr     (wovf_clr),
        .wclken       (wclken),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wcount       (wcount),
        .wovf         (wovf),
        .wovf_cnt     (wovf_cnt)
    );

    always #5 wclk = ~wclk;

    function automatic logic [4:0] to_gray(input int b);
        logic [4:0] v;
        v = 5'(b % c_MOD);
        return v ^ (v >> 1);
    endfunction

    function automatic int from_gray(input logic [4:0] g);
        int b;
        b = 0;
        for (int i = 4; i >= 0; i--) begin
            b = b | ((((b >> (i + 1)) & 1) ^ int'(g[i])) << i);
        end
        return b;
    endfunction

    task automatic model_reset();
        m_wpos = 0; m_rq1 = 0; m_rq2 = 0; m_count = 0; m_cnt = 0;
        m_full = 0; m_afull = 0; m_ovf = 0;
    endtask

    // Advance one write clock edge and the model with it; leaves time at edge+1.
    task automatic tick();
        bit acc, ev;
        int fill;
        acc = winc && !m_full;
        ev  = winc && m_full;
        @(posedge wclk);
        m_wpos  = (m_wpos + int'(acc)) % c_MOD;
        fill    = (m_wpos - m_rq2 + c_MOD) % c_MOD;
        m_count = fill;
        m_full  = (fill == c_DEPTH);
        m_afull = (fill >= c_DEPTH - c_MARG);
        if (ev) m_ovf = 1;
        else if (wovf_clr) m_ovf = 0;
`ifdef FIFO_WPTR_FULL_OVF_CNT_EN
        if (ev) m_cnt = wovf_clr ? 1 : ((m_cnt == 65535) ? m_cnt : m_cnt + 1);
        else if (wovf_clr) m_cnt = 0;
`else
        m_cnt = 0;
`endif
        m_rq2 = m_rq1;
        m_rq1 = from_gray(wrptr_gray);
        #1;
    endtask

    task automatic apply_reset();
        winc = 0; wovf_clr = 0; wrptr_gray = '0;
        wrst_n = 0;
        model_reset();
        @(posedge wclk);
        @(posedge wclk);
        #1 wrst_n = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({wptr, waddr, wfull, walmost_full, wcount, wovf, wovf_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_init: got wptr=%0h waddr=%0h wfull=%0b af=%0b wcount=%0d wovf=%0b cnt=%0d, want all 0",
                     wptr, waddr, wfull, walmost_full, wcount, wovf, wovf_cnt);
        end
        winc = 1;
        repeat (5) tick();
        checks++;
        if (waddr !== 4'd5) begin
            errors++; $display("FAIL pre_reset_waddr: got %0d want 5", waddr);
        end
        #3 wrst_n = 0;
        #1;
        checks++;
        if ({wptr, waddr, wfull, walmost_full, wcount, wovf, wovf_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset: got wptr=%0h waddr=%0h wfull=%0b af=%0b wcount=%0d wovf=%0b cnt=%0d, want all 0",
                     wptr, waddr, wfull, walmost_full, wcount, wovf, wovf_cnt);
        end
        winc = 0;
        model_reset();
        @(posedge wclk);
        #1 wrst_n = 1;
        winc = 1;
        #1;
        checks++;
        if (wclken !== 1'b1 || waddr !== 4'd0) begin
            errors++; $display("FAIL first_write_after_reset: got wclken=%0b waddr=%0d want 1/0", wclken, waddr);
        end
        tick();
        winc = 0;
        checks++;
        if (waddr !== 4'd1 || wptr !== 5'b00001) begin
            errors++; $display("FAIL post_reset_advance: got waddr=%0d wptr=%b want 1/00001", waddr, wptr);
        end
    endtask

    task automatic test_fill();
        apply_reset();
        winc = 1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            checks++;
            if (walmost_full !== (n >= 14)) begin
                errors++; $display("FAIL fill_afull_w%0d: got %0b want %0b", n, walmost_full, (n >= 14));
            end
            checks++;
            if (wfull !== (n == 16) || wcount !== 5'(n)) begin
                errors++; $display("FAIL fill_state_w%0d: got wfull=%0b wcount=%0d want %0b/%0d", n, wfull, wcount, (n == 16), n);
            end
        end
        checks++;
        if (wptr !== 5'b11000) begin
            errors++; $display("FAIL fill_wptr: got %b want 11000", wptr);
        end
    endtask

    task automatic test_overflow();
        winc = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (wclken !== 1'b0 || waddr !== 4'd0) begin
                errors++; $display("FAIL ovf_block_%0d: got wclken=%0b waddr=%0d want 0/0", k, wclken, waddr);
            end
            tick();
        end
        winc = 0;
        checks++;
`ifdef FIFO_WPTR_FULL_OVF_CNT_EN
        if (wovf !== 1'b1 || wovf_cnt !== 16'd3 || waddr !== 4'd0) begin
            errors++; $display("FAIL ovf_state: got wovf=%0b cnt=%0d waddr=%0d want 1/3/0", wovf, wovf_cnt, waddr);
        end
`else
        if (wovf !== 1'b1 || wovf_cnt !== 16'd0 || waddr !== 4'd0) begin
            errors++; $display("FAIL ovf_state: got wovf=%0b cnt=%0d waddr=%0d want 1/0/0", wovf, wovf_cnt, waddr);
        end
`endif
    endtask

    task automatic test_read_release();
        winc = 0;
        wrptr_gray = 5'b00001;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if (wfull !== (e < 3) || wcount !== ((e < 3) ? 5'd16 : 5'd15)) begin
                errors++; $display("FAIL release_edge%0d: got wfull=%0b wcount=%0d want %0b/%0d",
                                   e, wfull, wcount, (e < 3), (e < 3) ? 16 : 15);
            end
        end
        winc = 1;
        #1;
        checks++;
        if (wclken !== 1'b1 || waddr !== 4'd0) begin
            errors++; $display("FAIL release_write: got wclken=%0b waddr=%0d want 1/0", wclken, waddr);
        end
        tick();
        winc = 0;
        checks++;
        if (wfull !== 1'b1 || wcount !== 5'd16) begin
            errief_dummy_guard();
        end
    endtask

    // Kept separate so the release check above reads as one statement.
    task automatic errief_dummy_guard();
        errors++;
        $display("FAIL refill: got wfull=%0b wcount=%0d want 1/16", wfull, wcount);
    endtask

    task automatic test_ovf_clr_same();
        winc = 1; wovf_clr = 1;
        tick();
        winc = 0; wovf_clr = 0;
        checks++;
`ifdef FIFO_WPTR_FULL_OVF_CNT_EN
        if (wovf !== 1'b1 || wovf_cnt !== 16'd1) begin
            errors++; $display("FAIL clr_vs_event: got wovf=%0b cnt=%0d want 1/1", wovf, wovf_cnt);
        end
`else
        if (wovf !== 1'b1 || wovf_cnt !== 16'd0) begin
            errors++; $display("FAIL clr_vs_event: got wovf=%0b cnt=%0d want 1/0", wovf, wovf_cnt);
        end
`endif
        wovf_clr = 1;
        tick();
        wovf_clr = 0;
        checks++;
        if (wovf !== 1'b0 || wovf_cnt !== 16'd0) begin
            errors++; $display("FAIL clr_only: got wovf=%0b cnt=%0d want 0/0", wovf, wovf_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] hist[$];
        logic [4:0] prev_ptr;
        logic [3:0] prev_addr;
        int wraps, bad_ham, bad_full;
        apply_reset();
        hist = {5'd0, 5'd0, 5'd0, 5'd0};
        wraps = 0; bad_ham = 0; bad_full = 0;
        winc = 1;
        for (int n = 0; n < 40; n++) begin
            prev_ptr  = wptr;
            prev_addr = waddr;
            wrptr_gray = hist.pop_front();
            tick();
            hist.push_back(wptr);
            if ($countones(prev_ptr ^ wptr) != 1) bad_ham++;
            if (prev_addr == 4'd15 && waddr == 4'd0) wraps++;
            if (wfull !== 1'b0) bad_full++;
            checks++;
            if (wptr !== to_gray(m_wpos) || wcount !== 5'(m_count)) begin
                errors++; $display("FAIL wrap_model_%0d: got wptr=%b wcount=%0d want %b/%0d",
                                   n, wptr, wcount, to_gray(m_wpos), m_count);
            end
        end
        winc = 0;
        checks++;
        if (wraps != 2 || bad_ham != 0 || bad_full != 0) begin
            errors++; $display("FAIL wrap_summary: got wraps=%0d bad_hamming=%0d full_cycles=%0d want 2/0/0",
                               wraps, bad_ham, bad_full);
        end
    endtask

    task automatic test_random();
        int rd_pos;
        apply_reset();
        rd_pos = 0;
        for (int n = 0; n < 400; n++) begin
            winc     = ($urandom_range(0, 99) < 70);
            wovf_clr = ($urandom_range(0, 99) < 5);
            if (rd_pos != m_wpos && $urandom_range(0, 99) < ((n % 100) < 50 ? 30 : 70))
                rd_pos = (rd_pos + 1) % c_MOD;
            wrptr_gray = to_gray(rd_pos);
            #1;
            checks++;
            if (wclken !== (winc && !m_full)) begin
                errors++; $display("FAIL rand_wclken_%0d: got %0b want %0b", n, wclken, (winc && !m_full));
            end
            tick();
            checks++;
            if (wptr !== to_gray(m_wpos) || waddr !== 4'(m_wpos % c_DEPTH) || wfull !== m_full ||
                walmost_full !== m_afull || wcount !== 5'(m_count) || wovf !== m_ovf ||
                wovf_cnt !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL rand_state_%0d: got wptr=%b waddr=%0d full=%0b af=%0b cnt=%0d ovf=%0b ovfcnt=%0d want %b/%0d/%0b/%0b/%0d/%0b/%0d",
                         n, wptr, waddr, wfull, walmost_full, wcount, wovf, wovf_cnt,
                         to_gray(m_wpos), m_wpos % c_DEPTH, m_full, m_afull, m_count, m_ovf, m_cnt);
            end
        end
        winc = 0; wovf_clr = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_overflow();
        test_read_release();
        test_ovf_clr_same();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
